// File: rtl/scoreboard_scan.sv
// Multi-digit scoreboard scanner feeding a shared PMC14495-style hex-to-7-segment decoder.
// One digit per slot: blank period with decoder transparent, then latch and light the anode.
module scoreboard_scan #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     points,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [3:0]            D,
    output logic                  point,
    output logic                  LE,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start,
    output logic                  upd_ack
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned IW = $clog2(DIGITS);

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   act_val_q, act_val_d;
    logic [DIGITS-1:0]     act_pts_q, act_pts_d;
    logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [DIGITS-1:0]     pend_pts_q, pend_pts_d;
    logic                  pend_valid_q, pend_valid_d;

    logic                  last_cnt;
    logic                  boundary;
    logic                  upd;
    logic [3:0]            cur_nib;
    logic                  cur_pt;
    logic [DIGITS-1:0]     an_on;

    assign last_cnt = (cnt_q == CW'(SCAN_DIV - 1));
    assign boundary = (cnt_q == '0) && (idx_q == '0);

    always_comb begin
        cnt_d = last_cnt ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (last_cnt) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Frame boundary swaps pending into active; a load landing exactly on the
    // boundary skips pending so digit0 of this frame already shows it.
    always_comb begin
        act_val_d    = act_val_q;
        act_pts_d    = act_pts_q;
        pend_val_d   = pend_val_q;
        pend_pts_d   = pend_pts_q;
        pend_valid_d = pend_valid_q;
        upd          = 1'b0;
        if (boundary) begin
            pend_valid_d = 1'b0;
            if (load) begin
                act_val_d = value;
                act_pts_d = points;
                upd       = 1'b1;
            end else if (pend_valid_q) begin
                act_val_d = pend_val_q;
                act_pts_d = pend_pts_q;
                upd       = 1'b1;
            end
        end else if (load) begin
            pend_val_d   = value;
            pend_pts_d   = points;
            pend_valid_d = 1'b1;
        end
    end

    always_comb begin
        cur_nib = '0;
        cur_pt  = 1'b0;
        an_on   = '1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib  = act_val_d[4*i +: 4];
                cur_pt   = act_pts_d[i];
                an_on[i] = blank_mask[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            act_val_q    <= '0;
            act_pts_q    <= '0;
            pend_val_q   <= '0;
            pend_pts_q   <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_val_q    <= act_val_d;
            act_pts_q    <= act_pts_d;
            pend_val_q   <= pend_val_d;
            pend_pts_q   <= pend_pts_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // D/point only move at slot start, when LE is dropping and anodes are off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            D           <= '0;
            point       <= 1'b0;
            LE          <= 1'b0;
            an          <= '1;
            frame_start <= 1'b0;
            upd_ack     <= 1'b0;
        end else begin
            frame_start <= boundary;
            upd_ack     <= upd;
            if (cnt_q == '0) begin
                D     <= cur_nib;
                point <= cur_pt;
                LE    <= 1'b0;
                an    <= '1;
            end else if (cnt_q == CW'(BLANK_CYC)) begin
                LE <= 1'b1;
                an <= an_on;
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_scan.sv
// Self-checking bench for scoreboard_scan: per-cycle output model with a load scoreboard
// that is drained at each frame boundary (last load wins).
module tb_scoreboard_scan;

    localparam int unsigned DIGITS    = 4;
    localparam int unsigned SCAN_DIV  = 8;
    localparam int unsigned BLANK_CYC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  points;
    logic [3:0]  blank_mask;
    logic [3:0]  D;
    logic        point;
    logic        LE;
    logic [3:0]  an;
    logic        frame_start;
    logic        upd_ack;

    scoreboard_scan #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .points      (points),
        .blank_mask  (blank_mask),
        .D           (D),
        .point       (point),
        .LE          (LE),
        .an          (an),
        .frame_start (frame_start),
        .upd_ack     (upd_ack)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // scoreboard of loads not yet displayed: {points, value}
    logic [19:0] exp_q[$];
    logic [15:0] cur_val;
    logic [3:0]  cur_pts;
    logic        bm_s;
    int          g;
    logic        prev_le;
    logic [4:0]  prev_pd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t g=%0d)", tag, obs, exp, $time, g);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, {28'b0, an}, 32'hF);
        check({tag, "_le"}, {31'b0, LE}, 32'h0);
        check({tag, "_d"}, {28'b0, D}, 32'h0);
        check({tag, "_point"}, {31'b0, point}, 32'h0);
        check({tag, "_fs"}, {31'b0, frame_start}, 32'h0);
        check({tag, "_ack"}, {31'b0, upd_ack}, 32'h0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur_val = '0;
        cur_pts = '0;
        bm_s    = 1'b0;
        g       = -1;
        prev_le = 1'b0;
        prev_pd = '0;
    endtask

    // Advance one clock and compare every output against the model.
    task automatic tick();
        int s;
        int p;
        logic       bnd;
        logic       e_ack;
        logic [3:0] e_an;
        logic [19:0] top;
        @(posedge clk);
        #1;
        g++;
        s     = (g / int'(SCAN_DIV)) % int'(DIGITS);
        p     = g % int'(SCAN_DIV);
        bnd   = (s == 0) && (p == 0);
        e_ack = 1'b0;
        if (bnd && exp_q.size() > 0) begin
            top = exp_q[$];
            exp_q.delete();
            cur_pts = top[19:16];
            cur_val = top[15:0];
            e_ack   = 1'b1;
        end
        if (p == int'(BLANK_CYC)) bm_s = blank_mask[s];
        e_an = 4'hF;
        if (p >= int'(BLANK_CYC) && !bm_s) e_an[s] = 1'b0;
        check("frame_start", {31'b0, frame_start}, {31'b0, bnd});
        check("upd_ack", {31'b0, upd_ack}, {31'b0, e_ack});
        check("an", {28'b0, an}, {28'b0, e_an});
        check("le", {31'b0, LE}, {31'b0, (p >= int'(BLANK_CYC))});
        check("d", {28'b0, D}, {28'b0, cur_val[4*s +: 4]});
        check("point", {31'b0, point}, {31'b0, cur_pts[s]});
        check("an_onecold", {31'b0, ($countones(~an) <= 1)}, 32'h1);
        if (LE && prev_le) check("d_hold", {27'b0, point, D}, {27'b0, prev_pd});
        prev_le = LE;
        prev_pd = {point, D};
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] p);
        load   = 1'b1;
        value  = v;
        points = p;
        exp_q.push_back({p, v});
        tick();
        load   = 1'b0;
        value  = $urandom();
        points = 4'($urandom());
    endtask

    task automatic run_to_frame_end();
        while ((g % 32) != 31) tick();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        value      = '0;
        points     = '0;
        blank_mask = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        release_reset();

        // Frame of zeros, then 1A2B with point on digit 2
        run(5);
        do_load(16'h1A2B, 4'b0100);
        run_to_frame_end();
        run(32);

        // Two loads in one frame: only the last is shown
        run(4);
        do_load(16'h1234, 4'b0001);
        run(6);
        do_load(16'h5678, 4'b0010);
        run_to_frame_end();
        run(32);

        // Load exactly on the boundary cycle bypasses pending
        run_to_frame_end();
        do_load(16'h9C3E, 4'b1001);
        run(31);
        run(32);

        // Digit 3 blanked for three frames
        blank_mask = 4'b1000;
        run(96);
        blank_mask = 4'b0000;
        run(32);

        // Mid-slot reset loses pending data
        run(9);
        do_load(16'h4321, 4'b1111);
        run(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        release_reset();
        run(64);

        // Random loads at random times
        for (int k = 0; k < 6; k++) begin
            run($urandom_range(0, 40));
            do_load(16'($urandom()), 4'($urandom()));
        end
        run_to_frame_end();
        run(32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
